multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle MIPS control FSM; successor of the single-cycle opcode decoder.
//  Sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory port with a req/ready handshake.
//  Drives datapath muxes and write enables per state, bounds memory waits with a timeout counter.
//  Same instruction set: R-type, JR, ADDI, ORI, LUI, BEQ, BNE, LW, SW, J, JAL.
// PARAMETERS
//  ALUOP_W      3   ALUOp width; codes below zero-extended (must be >=3)
//  MEM_TIMEOUT  15  max wait cycles per memory access before ERROR (1..255)
//  CNT_W        8   wait-counter width (2^CNT_W > MEM_TIMEOUT)
// PORTS
//  clk         in   1        clock, rising edge
//  reset       in   1        asynchronous, active-low reset
//  OP          in   6        instr[31:26], valid from DECODE onward (IR output)
//  Funct       in   6        instr[5:0]
//  mem_ready   in   1        memory completes the current access this cycle
//  mem_req     out  1        memory access request, held until mem_ready
//  MemRead     out  1        read strobe (FETCH, MEM_RD)
//  MemWrite    out  1        write strobe (MEM_WR)
//  IorD        out  1        0=PC address, 1=ALUOut address
//  IRWrite     out  1        load instruction register
//  PCWrite     out  1        unconditional PC load
//  BranchEQ    out  1        PC load if zero; BranchNE: out 1, PC load if !zero
//  PCSource    out  2        00=ALU, 01=ALUOut, 10=jump target, 11=register rs
//  ALUSrcA     out  1        0=PC, 1=rs
//  ALUSrcB     out  2        00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  ALUOp       out  ALUOP_W  111 R/funct, 100 add-imm, 101 or, 110 lui, 011 add, 000 beq, 001 bne
//  RegDst      out  2        00=rt, 01=rd, 10=$31
//  MemtoReg    out  2        00=ALUOut, 01=MDR, 10=PC (link)
//  RegWrite    out  1        register file write enable
//  busy        out  1        1 in any state except FETCH-waiting-for-first-ready
//  error       out  1        sticky memory-timeout flag
//  trap        out  1        illegal-opcode pulse (only with ILLEGAL_TRAP_EN)
// BEHAVIOUR
//  Reset (reset=0, async): state=FETCH, wait counter=0, error=0; all outputs 0 except mem_req/MemRead=1 after release.
//  All outputs decoded from state register (Moore) except mem_ready-qualified IRWrite/PCWrite in FETCH.
//  FETCH: mem_req=MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=011, PCSource=00;
//   on mem_ready: IRWrite=PCWrite=1 same cycle, -> DECODE; else stay, counter++.
//  DECODE (1 cycle): ALUSrcA=0, ALUSrcB=11, ALUOp=011 (branch target into ALUOut). Next by OP:
//   0/Funct=08 -> JR; 0 -> EXEC_R; 08/0d/0f -> EXEC_I; 23/2b -> MEM_ADDR; 04/05 -> BRANCH; 02 -> JUMP; 03 -> JAL.
//  EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=111 -> R_WB: RegDst=01, MemtoReg=00, RegWrite=1 -> FETCH.
//  EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=100/101/110 -> I_WB: RegDst=00, RegWrite=1 -> FETCH.
//  MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=011 -> MEM_RD (LW) or MEM_WR (SW).
//  MEM_RD: mem_req=MemRead=1, IorD=1; wait for mem_ready -> LW_WB: RegDst=00, MemtoReg=01, RegWrite=1 -> FETCH.
//  MEM_WR: mem_req=MemWrite=1, IorD=1; on mem_ready -> FETCH.
//  BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=000/001, BranchEQ or BranchNE=1, PCSource=01 -> FETCH.
//  JUMP: PCWrite=1, PCSource=10 -> FETCH. JR: PCWrite=1, PCSource=11 -> FETCH.
//  JAL: PCWrite=1, PCSource=10, RegDst=10, MemtoReg=10, RegWrite=1 (old PC+4 linked) -> FETCH.
//  Wait counter: cleared on entry to any memory state and on mem_ready; increments each non-ready cycle;
//   counter==MEM_TIMEOUT without ready -> ERROR: all enables 0, mem_req=0, error=1, held until reset.
//  mem_ready outside a memory state is ignored. mem_req never drops before mem_ready (no abort).
//  Reset mid-access: immediate return to FETCH, no write enable asserted in the reset cycle.
//  Instruction CPI: R/I 4, LW 5+waits, SW 4+waits, branch/jump 3 (plus FETCH waits).
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: unlisted OP (or OP=0 with unsupported Funct? no: only OP checked)
//   -> TRAP state 1 cycle: trap=1, PCWrite=1, PCSource=11 (datapath muxes vector), no RegWrite -> FETCH.
//  Not defined: unlisted OP -> FETCH directly from DECODE (NOP, no enables); trap tied 0.
// TESTING
//  ADD (OP=0,Funct=20), mem_ready=1 in FETCH -> 4 cycles; R_WB has RegDst=01, RegWrite=1, ALUOp=111.
//  LW (OP=23), mem_ready low 3 cycles in MEM_RD -> mem_req held 4 cycles, RegWrite+MemtoReg=01 after ready, CPI=8.
//  SW with mem_ready never asserted -> ERROR after exactly 15 wait cycles, error=1, MemWrite=0 thereafter until reset.
//  JAL (OP=03) -> JAL state: PCSource=10, RegDst=10, MemtoReg=10, RegWrite=1; JR (OP=0,Funct=08) -> PCSource=11, RegWrite=0.
//  BNE (OP=05) -> BRANCH: BranchNE=1, BranchEQ=0, ALUOp=001, PCSource=01; back to FETCH next cycle.
//  OP=3f with/without ILLEGAL_TRAP_EN -> trap pulse + PCSource=11 / silent return to FETCH; reset asserted mid-MEM_RD -> FETCH, error=0.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control -- multi-cycle MIPS control FSM.
//
// Steps each instruction through FETCH / DECODE / execute / memory / write-back
// over one shared memory port using a req/ready handshake. Every datapath mux
// select and write enable is decoded from the state register. IRWrite and PCWrite
// are the exception: in FETCH they are qualified by mem_ready. A wait counter
// limits each memory access. When it runs out, the FSM parks in ERROR until reset.
//
// Optional feature (compile-time macro ILLEGAL_TRAP_EN):
//   defined   : an unlisted opcode enters a one-cycle TRAP state. TRAP pulses trap,
//               loads the PC from the rs/vector mux (PCSource=11) and writes no register.
//   undefined : an unlisted opcode returns straight from DECODE to FETCH as a NOP,
//               and trap is tied low.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   OP, Funct  in   instruction opcode / function fields (from IR, valid from DECODE)
//   mem_ready  in   memory completes the current access this cycle
//   mem_req    out  memory request, held until mem_ready
//   MemRead, MemWrite, IorD, IRWrite, PCWrite, BranchEQ, BranchNE, PCSource,
//   ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite
//              out  datapath controls
//   busy       out  low only while FETCH waits for an instruction
//   error      out  sticky memory-timeout flag
//   trap       out  illegal-opcode pulse
module multicycle_control #(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OP,
    input  logic [5:0]         Funct,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IorD,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               BranchEQ,
    output logic               BranchNE,
    output logic [1:0]         PCSource,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic               RegWrite,
    output logic               busy,
    output logic               error,
    output logic               trap
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Last non-ready cycle allowed: its count would reach MEM_TIMEOUT.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB, S_MEM_ADDR, S_MEM_RD,
        S_LW_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JR, S_JAL, S_TRAP, S_ERROR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [2:0]       alu_op3;

    function automatic logic [2:0] imm_aluop(input logic [5:0] op);
        case (op)
            OP_ORI:  return 3'b101;
            OP_LUI:  return 3'b110;
            default: return 3'b100;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_FETCH, S_MEM_RD, S_MEM_WR: begin
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        case (state)
                            S_FETCH:  state <= S_DECODE;
                            S_MEM_RD: state <= S_LW_WB;
                            default:  state <= S_FETCH;
                        endcase
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_LAST) state <= S_ERROR;
                    end
                end
                S_DECODE: begin
                    wait_cnt <= '0;
                    case (OP)
                        OP_RTYPE:               state <= (Funct == FN_JR) ? S_JR : S_EXEC_R;
                        OP_ADDI, OP_ORI, OP_LUI: state <= S_EXEC_I;
                        OP_LW, OP_SW:           state <= S_MEM_ADDR;
                        OP_BEQ, OP_BNE:         state <= S_BRANCH;
                        OP_J:                   state <= S_JUMP;
                        OP_JAL:                 state <= S_JAL;
`ifdef ILLEGAL_TRAP_EN
                        default:                state <= S_TRAP;
`else
                        default:                state <= S_FETCH;
`endif
                    endcase
                end
                S_EXEC_R:   begin wait_cnt <= '0; state <= S_R_WB; end
                S_EXEC_I:   begin wait_cnt <= '0; state <= S_I_WB; end
                S_MEM_ADDR: begin
                    wait_cnt <= '0;
                    state    <= (OP == OP_LW) ? S_MEM_RD : S_MEM_WR;
                end
                // ERROR holds; only reset leaves it.
                S_ERROR:    state <= S_ERROR;
                default:    begin wait_cnt <= '0; state <= S_FETCH; end
            endcase
        end
    end

    // Outputs are forced low while reset is held, so no enable fires in the reset cycle.
    always_comb begin
        mem_req  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        BranchEQ = 1'b0;
        BranchNE = 1'b0;
        PCSource = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        alu_op3  = 3'b000;
        RegDst   = 2'b00;
        MemtoReg = 2'b00;
        RegWrite = 1'b0;
        busy     = 1'b0;
        error    = 1'b0;
        trap     = 1'b0;
        if (reset) begin
            busy  = (state != S_FETCH);
            error = (state == S_ERROR);
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    alu_op3 = 3'b011;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    alu_op3 = 3'b011;
                end
                S_EXEC_R, S_R_WB: begin
                    ALUSrcA = 1'b1;
                    alu_op3 = 3'b111;
                    if (state == S_R_WB) begin
                        RegDst   = 2'b01;
                        RegWrite = 1'b1;
                    end
                end
                S_EXEC_I, S_I_WB: begin
                    ALUSrcA  = 1'b1;
                    ALUSrcB  = 2'b10;
                    alu_op3  = imm_aluop(OP);
                    RegWrite = (state == S_I_WB);
                end
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    alu_op3 = 3'b011;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_LW_WB: begin
                    MemtoReg = 2'b01;
                    RegWrite = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA  = 1'b1;
                    alu_op3  = (OP == OP_BNE) ? 3'b001 : 3'b000;
                    BranchNE = (OP == OP_BNE);
                    BranchEQ = (OP != OP_BNE);
                    PCSource = 2'b01;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_JR: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b11;
                end
                S_JAL: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                    RegWrite = 1'b1;
                end
`ifdef ILLEGAL_TRAP_EN
                S_TRAP: begin
                    trap     = 1'b1;
                    PCWrite  = 1'b1;
                    PCSource = 2'b11;
                end
`endif
                default: ;
            endcase
        end
    end

    assign ALUOp = ALUOP_W'(alu_op3);

endmodule
